// File: rtl/debounce_array.sv
// debounce_array: multi-channel switch conditioner.
// Each channel has a synchroniser, a consecutive-cycle stability filter, and
// press / release / long-press event generation. Channels share nothing.
module debounce_array #(
    parameter int   NUM_CH          = 4,
    parameter int   DEBOUNCE_TIME   = 500000,
    parameter int   LONG_PRESS_TIME = 12000000,
    parameter int   CNT_W           = 24,
    parameter int   SYNC_STAGES     = 2,
    parameter logic ACTIVE_LEVEL    = 1'b1,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] sw_in_i,
    output logic [NUM_CH-1:0] sw_debounced_o,
    output logic [NUM_CH-1:0] press_o,
    output logic [NUM_CH-1:0] release_o,
    output logic [NUM_CH-1:0] long_press_o
);

    // Largest value a CNT_W-bit counter can hold; both time parameters must fit.
    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

    // Last filter count before a commit; the filter counter never exceeds it.
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_TIME - 1);

    // Parameter sanity checks, rejected at elaboration.
    if (NUM_CH < 1) begin : g_bad_num_ch
        $error("debounce_array: NUM_CH must be at least 1");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("debounce_array: SYNC_STAGES must be between 2 and 4");
    end
    if (DEBOUNCE_TIME < 1 || longint'(DEBOUNCE_TIME) > CNT_MAX) begin : g_bad_deb
        $error("debounce_array: DEBOUNCE_TIME must be in 1 .. 2^CNT_W-1");
    end
    if (LONG_PRESS_TIME < 0 || longint'(LONG_PRESS_TIME) > CNT_MAX) begin : g_bad_long
        $error("debounce_array: LONG_PRESS_TIME must be in 0 .. 2^CNT_W-1");
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch

        logic [SYNC_STAGES-1:0] sync_q;
        logic                   sync_s;

        logic                   deb_q;
        logic                   deb_d;
        logic [CNT_W-1:0]       filt_q;
        logic [CNT_W-1:0]       filt_d;
        logic                   press_q;
        logic                   press_d;
        logic                   rel_q;
        logic                   rel_d;

        // Metastability synchroniser: shift the raw pin through a flop chain.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= {SYNC_STAGES{RESET_LEVEL}};
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], sw_in_i[ch]};
            end
        end

        assign sync_s = sync_q[SYNC_STAGES-1];

        // Stability filter: commit only after DEBOUNCE_TIME consecutive disagreeing cycles.
        always_comb begin
            deb_d   = deb_q;
            filt_d  = filt_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            if (sync_s == deb_q) begin
                filt_d = '0;
            end else if (filt_q == DEB_LAST) begin
                deb_d  = sync_s;
                filt_d = '0;
                if (sync_s == ACTIVE_LEVEL) begin
                    press_d = 1'b1;
                end else begin
                    rel_d = 1'b1;
                end
            end else begin
                filt_d = filt_q + CNT_W'(1);
            end
        end

        // Committed level, filter count and single-cycle press/release pulses.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                deb_q   <= RESET_LEVEL;
                filt_q  <= '0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                deb_q   <= deb_d;
                filt_q  <= filt_d;
                press_q <= press_d;
                rel_q   <= rel_d;
            end
        end

        assign sw_debounced_o[ch] = deb_q;
        assign press_o[ch]        = press_q;
        assign release_o[ch]      = rel_q;

        if (LONG_PRESS_TIME > 0) begin : g_hold

            localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_PRESS_TIME - 1);

            logic [CNT_W-1:0] hold_q;
            logic [CNT_W-1:0] hold_d;
            logic             fired_q;
            logic             fired_d;
            logic             long_q;
            logic             long_d;
            logic             held;

            // Held means active now and not being released on this edge, so a
            // release that coincides with the firing edge suppresses long_press.
            assign held = (deb_q == ACTIVE_LEVEL) && !rel_d;

            // Hold timer: count while held, fire once, then stay put until released.
            always_comb begin
                hold_d  = hold_q;
                fired_d = fired_q;
                long_d  = 1'b0;
                if (!held) begin
                    hold_d  = '0;
                    fired_d = 1'b0;
                end else if (!fired_q) begin
                    if (hold_q == HOLD_LAST) begin
                        long_d  = 1'b1;
                        fired_d = 1'b1;
                    end else begin
                        hold_d = hold_q + CNT_W'(1);
                    end
                end
            end

            // Hold counter, fired flag and long-press pulse registers.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hold_q  <= '0;
                    fired_q <= 1'b0;
                    long_q  <= 1'b0;
                end else begin
                    hold_q  <= hold_d;
                    fired_q <= fired_d;
                    long_q  <= long_d;
                end
            end

            assign long_press_o[ch] = long_q;

        end else begin : g_no_hold

            assign long_press_o[ch] = 1'b0;

        end
    end

endmodule

// File: tb/tb_debounce_array.sv
// tb_debounce_array: directed bench for debounce_array with a per-channel
// reference model compared every cycle and hand-timed event checks.
module tb_debounce_array;

   localparam int NCH = 2;
   localparam int DT  = 8;
   localparam int LPT = 20;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [NCH-1:0] sw_in;
   logic [NCH-1:0] deb;
   logic [NCH-1:0] press;
   logic [NCH-1:0] rel;
   logic [NCH-1:0] lp;

   int checks = 0;
   int errors = 0;
   bit checkEn = 1'b0;

   int pressCnt [NCH];
   int relCnt [NCH];
   int longCnt [NCH];

   int snapA;
   int snapB;

   typedef struct {
      logic [1:0] sw;
      int         dur;
   } vec_t;

   vec_t tbl [12] = '{
      '{2'b01, 12}, '{2'b11, 5}, '{2'b10, 9}, '{2'b00, 3},
      '{2'b01, 8}, '{2'b11, 30}, '{2'b10, 7}, '{2'b00, 25},
      '{2'b11, 8}, '{2'b01, 40}, '{2'b10, 16}, '{2'b00, 15}
   };

   // 10 ns clock
   always #5 clk = ~clk;

   debounce_array #(
      .NUM_CH(NCH),
      .DEBOUNCE_TIME(DT),
      .LONG_PRESS_TIME(LPT),
      .CNT_W(24),
      .SYNC_STAGES(2),
      .ACTIVE_LEVEL(1'b1),
      .RESET_LEVEL(1'b0)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .sw_in_i(sw_in),
      .sw_debounced_o(deb),
      .press_o(press),
      .release_o(rel),
      .long_press_o(lp)
   );

   // single comparison point: counts every check and reports any mismatch
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] v);
      sw_in = v;
   endtask

   task automatic waitEdges(input int n);
      repeat (n) @(negedge clk);
   endtask

   // reference model: run-length of disagreeing synchronised samples per channel
   bit ms1 [NCH];
   bit ms2 [NCH];
   bit mdeb [NCH];
   bit mp [NCH];
   bit mr [NCH];
   bit ml [NCH];
   bit mfired [NCH];
   int mrun [NCH];
   int mhold [NCH];
   bit s, nd, p, r, l;

   // model updates on the same edges as the design, reset asynchronously
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NCH; c++) begin
            ms1[c] = 1'b0; ms2[c] = 1'b0; mdeb[c] = 1'b0;
            mp[c] = 1'b0; mr[c] = 1'b0; ml[c] = 1'b0; mfired[c] = 1'b0;
            mrun[c] = 0; mhold[c] = 0;
         end
      end else begin
         for (int c = 0; c < NCH; c++) begin
            s = ms2[c]; nd = mdeb[c]; p = 1'b0; r = 1'b0; l = 1'b0;
            if (s != mdeb[c]) begin
               if (mrun[c] + 1 == DT) begin
                  nd = s; mrun[c] = 0; p = s; r = !s;
               end else begin
                  mrun[c]++;
               end
            end else begin
               mrun[c] = 0;
            end
            if (mdeb[c] && !r) begin
               if (!mfired[c]) begin
                  if (mhold[c] == LPT - 1) begin
                     l = 1'b1; mfired[c] = 1'b1;
                  end else begin
                     mhold[c]++;
                  end
               end
            end else begin
               mhold[c] = 0; mfired[c] = 1'b0;
            end
            ms2[c] = ms1[c]; ms1[c] = sw_in[c];
            mdeb[c] = nd; mp[c] = p; mr[c] = r; ml[c] = l;
         end
      end
   end

   // compare every channel against the model and tally events, away from the active edge
   always @(negedge clk) begin
      if (rst_n === 1'b1 && checkEn) begin
         for (int c = 0; c < NCH; c++) begin
            checkOutput($sformatf("model ch%0d {deb,press,rel,long}", c),
                        {28'd0, deb[c], press[c], rel[c], lp[c]},
                        {28'd0, mdeb[c], mp[c], mr[c], ml[c]});
            if (press[c] === 1'b1) pressCnt[c]++;
            if (rel[c] === 1'b1) relCnt[c]++;
            if (lp[c] === 1'b1) longCnt[c]++;
         end
      end
   end

   initial begin
      for (int c = 0; c < NCH; c++) begin
         pressCnt[c] = 0; relCnt[c] = 0; longCnt[c] = 0;
      end
      rst_n = 1'b0;
      sw_in = 2'b00;
      waitEdges(3);
      rst_n = 1'b1;
      checkEn = 1'b1;
      checkOutput("reset deb", 32'(deb), 32'd0);
      checkOutput("reset press", 32'(press), 32'd0);

      // get both channels committed high before the mid-clock reset
      applyStimulus(2'b11);
      waitEdges(12);
      checkOutput("pre-reset deb", 32'(deb), 32'd3);

      // test 1: asynchronous reset mid-clock, then restart with inputs high
      $display("[TB] test 1: async reset");
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checkOutput("async reset deb", 32'(deb), 32'd0);
      checkOutput("async reset press", 32'(press), 32'd0);
      checkOutput("async reset release", 32'(rel), 32'd0);
      checkOutput("async reset long", 32'(lp), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      waitEdges(9);
      checkOutput("restart edge9 deb", 32'(deb), 32'd0);
      waitEdges(1);
      checkOutput("restart edge10 deb", 32'(deb), 32'd3);
      checkOutput("restart edge10 press", 32'(press), 32'd3);
      waitEdges(1);
      checkOutput("restart edge11 press", 32'(press), 32'd0);

      // test 2: glitch rejection on ch0
      $display("[TB] test 2: glitch rejection");
      applyStimulus(2'b10);
      waitEdges(10);
      checkOutput("ch0 low deb", 32'(deb), 32'd2);
      checkOutput("ch0 low release", 32'(rel), 32'd1);
      waitEdges(2);
      #1 snapA = pressCnt[0];
      for (int i = 0; i < 3; i++) begin
         applyStimulus(2'b11);
         waitEdges(7);
         applyStimulus(2'b10);
         waitEdges(4);
         checkOutput($sformatf("glitch %0d deb", i), 32'(deb), 32'd2);
      end
      #1 checkOutput("glitch press count", 32'(pressCnt[0]), 32'(snapA));
      applyStimulus(2'b11);
      waitEdges(9);
      checkOutput("commit edge9 deb", 32'(deb), 32'd2);
      waitEdges(1);
      checkOutput("commit edge10 deb", 32'(deb), 32'd3);
      checkOutput("commit edge10 press", 32'(press), 32'd1);

      // test 4: long press fires once, LPT cycles after press
      $display("[TB] test 4: long press");
      snapB = longCnt[0];
      waitEdges(19);
      checkOutput("long P+19", 32'(lp), 32'd0);
      waitEdges(1);
      checkOutput("long P+20", 32'(lp), 32'd1);
      waitEdges(1);
      checkOutput("long P+21", 32'(lp), 32'd0);
      waitEdges(20);
      #1 checkOutput("long no repeat", 32'(longCnt[0]), 32'(snapB + 1));

      // test 3: ch1 release path
      $display("[TB] test 3: release path");
      snapA = pressCnt[1];
      applyStimulus(2'b01);
      waitEdges(9);
      checkOutput("rel edge9 deb", 32'(deb), 32'd3);
      checkOutput("rel edge9 release", 32'(rel), 32'd0);
      waitEdges(1);
      checkOutput("rel edge10 deb", 32'(deb), 32'd1);
      checkOutput("rel edge10 release", 32'(rel), 32'd2);
      waitEdges(1);
      checkOutput("rel edge11 release", 32'(rel), 32'd0);
      #1 checkOutput("ch1 no press", 32'(pressCnt[1]), 32'(snapA));

      // release and re-press ch0: long press fires again
      applyStimulus(2'b00);
      waitEdges(10);
      checkOutput("ch0 release", 32'(rel), 32'd1);
      applyStimulus(2'b01);
      waitEdges(10);
      checkOutput("re-press", 32'(press), 32'd1);
      waitEdges(20);
      checkOutput("re-press long", 32'(lp), 32'd1);
      waitEdges(5);
      #1 checkOutput("re-press long count", 32'(longCnt[0]), 32'(snapB + 2));

      // test 5: early release at hold count 15, then release on the firing edge
      $display("[TB] test 5: early release");
      applyStimulus(2'b00);
      waitEdges(12);
      applyStimulus(2'b01);
      waitEdges(10);
      checkOutput("early press", 32'(press), 32'd1);
      waitEdges(6);
      applyStimulus(2'b00);
      waitEdges(9);
      checkOutput("early P+15 deb", 32'(deb), 32'd1);
      waitEdges(1);
      checkOutput("early P+16 deb", 32'(deb), 32'd0);
      checkOutput("early P+16 release", 32'(rel), 32'd1);
      waitEdges(25);
      #1 checkOutput("early no long", 32'(longCnt[0]), 32'(snapB + 2));
      applyStimulus(2'b01);
      waitEdges(10);
      checkOutput("tie press", 32'(press), 32'd1);
      waitEdges(10);
      applyStimulus(2'b00);
      waitEdges(10);
      checkOutput("tie P+20 release", 32'(rel), 32'd1);
      checkOutput("tie P+20 long", 32'(lp), 32'd0);
      waitEdges(5);
      #1 checkOutput("tie no long", 32'(longCnt[0]), 32'(snapB + 2));
      applyStimulus(2'b01);
      waitEdges(10);
      checkOutput("restart press", 32'(press), 32'd1);
      waitEdges(19);
      checkOutput("restart P+19 long", 32'(lp), 32'd0);
      waitEdges(1);
      checkOutput("restart P+20 long", 32'(lp), 32'd1);

      // test 6: staggered overlapping toggles, checked cycle-by-cycle against the model
      $display("[TB] test 6: channel independence");
      for (int i = 0; i < 12; i++) begin
         applyStimulus(tbl[i].sw);
         waitEdges(tbl[i].dur);
      end
      waitEdges(5);
      checkOutput("final deb", 32'(deb), 32'd0);

      checkEn = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
